uart_loader: RTL
================

// Module: uart_loader
// PURPOSE
//  Boot-image loader between the UART byte receiver and the SDRAM controller write port.
//  Pairs received bytes into 16-bit words, buffers them in a small FIFO and writes them to
//  consecutive DRAM word addresses while load_en is high. The top level muxes its outputs
//  onto the sdram_ctl request port whenever SW[1] (load_en) is set.
// PARAMETERS
//  ADDR_WIDTH  25  width of the DRAM word address
//  FIFO_DEPTH  4   word FIFO entries (power of two, >=2)
//  BASE_ADDR   0   DRAM address of the first loaded word
// PORTS
//  clk              in   1           system clock (MAX10_CLK1_50)
//  rst              in   1           asynchronous, active-low reset
//  load_en          in   1           load-mode switch, asynchronous; 2-flop synchronised inside
//  rx_byte          in   8           byte from uart_rx, valid when rx_byte_ready rises
//  rx_byte_ready    in   1           uart_rx data_ready; only its rising edge is used
//  dram_mem_ready   in   1           sdram_ctl initialisation done
//  dram_data_ready  in   1           sdram_ctl 1-cycle pulse: current write complete
//  dram_write_en    out  1           write qualifier, constant 1 while a request is pending
//  dram_refresh_data out 1           1-cycle request strobe to sdram_ctl
//  dram_addr        out  ADDR_WIDTH  write address
//  dram_data_in     out  16          write data
//  word_count       out  16          words committed to DRAM since last load_en rise
//  busy             out  1           FIFO non-empty or write in flight
//  overflow         out  1           sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0; dram_addr=BASE_ADDR; byte phase=HI; FIFO empty; state IDLE.
//  Assembler: first byte -> data[15:8], second byte -> data[7:0]. The second byte's edge pushes
//   the word into the FIFO on the next clk. Bytes are ignored while synced load_en=0.
//  FIFO full on push: word dropped, overflow<=1 (cleared only by rst or load_en rise).
//  Writer FSM:
//   IDLE  : FIFO non-empty && dram_mem_ready -> drive addr/data from head, strobe 1 cycle, -> WAIT
//   WAIT  : hold addr/data stable; on dram_data_ready -> pop, word_count++, dram_addr++, -> IDLE
//   Minimum 3 cycles per word: strobe, ack, back-to-back re-issue from IDLE.
//  load_en rise (synced): word_count=0, dram_addr=BASE_ADDR, phase=HI, FIFO flushed, overflow=0.
//   If the rise occurs in WAIT, the flush and counter clears take effect after the ack.
//  load_en fall: a pending odd byte is discarded; the FIFO keeps draining to DRAM; busy falls
//   when the FIFO is empty and the FSM is in IDLE.
//  Wrap: dram_addr and word_count wrap modulo 2^ADDR_WIDTH and 2^16 respectively, with no flag.
//  Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
//  rst asserted mid-write: immediate return to the reset state; the in-flight DRAM write is
//   abandoned.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: extra output checksum[15:0], the mod-2^16 sum of the words
//   committed since the last load_en rise. It is updated on each ack and cleared with
//   word_count.
//  LOADER_CHECKSUM_EN undefined: no checksum port and no adder; all other behaviour is identical.
// STRUCTURE
//  Shared defs package: WORD_WIDTH (16), the writer state enum {IDLE, WAIT}, BYTE_HI/BYTE_LO.
//  One sub-module, loader_word_fifo (sync FIFO with push/pop/full/empty/flush), parameterised
//   by FIFO_DEPTH. Assembler, edge detectors, synchroniser and FSM stay in uart_loader.
// TESTING
//  1. Set load_en, send bytes 12 34 AB CD, ack every request after 2 cycles
//     -> DRAM writes 0x1234@0 and 0xABCD@1; word_count=2; busy returns to 0.
//  2. Hold dram_data_ready low and send 6 words with FIFO_DEPTH=4
//     -> 4 buffered, overflow=1; after ack resumes exactly 4 writes at addresses 0..3.
//  3. Send byte 55, drop load_en, raise it again, send 01 02
//     -> single write 0x0102@0; 0x55 is never written.
//  4. Keep dram_mem_ready=0 and send 2 words
//     -> no strobe; when mem_ready is raised, writes issue in order @0 and @1.
//  5. Assert rst while in WAIT
//     -> all outputs 0 in the same cycle; a following load restarts at BASE_ADDR.
//  6. With LOADER_CHECKSUM_EN, load 0xFFFF and 0x0002 -> checksum=0x0001.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot-image loader.
package uart_loader_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wr_state_t;

  typedef enum logic {
    BYTE_HI = 1'b0,
    BYTE_LO = 1'b1
  } byte_phase_t;

endpackage

// File: rtl/uart_loader_fifo.sv
// Synchronous word FIFO for the loader: push/pop/flush, full/empty, drop indication.
module loader_word_fifo
  import uart_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push & ~flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_loader.sv
// UART-to-SDRAM boot-image loader: byte pairing, word FIFO and a write FSM.
// Optional checksum output is enabled with `define LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | no write outstanding; issues the FIFO head when DRAM is ready
// WAIT  | request strobed; addr/data held until dram_data_ready
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 25,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [BYTE_WIDTH-1:0] rx_byte,
  input  logic                  rx_byte_ready,
  input  logic                  dram_mem_ready,
  input  logic                  dram_data_ready,
  output logic                  dram_write_en,
  output logic                  dram_refresh_data,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [WORD_WIDTH-1:0] dram_data_in,
  output logic [15:0]           word_count,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic                  busy,
  output logic                  overflow
);

  logic le_s1, le_s2, le_d;
  logic le_rise, le_fall;
  logic rdy_d, rx_edge;

  byte_phase_t           phase;
  logic [BYTE_WIDTH-1:0] hi_byte;
  logic                  push_q;
  logic [WORD_WIDTH-1:0] push_word;

  wr_state_t state, state_nxt;
  logic      clr_pend, do_clear;
  logic      issue, ack;

  logic [WORD_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_dropped;

  logic                  strobe_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           count_q;
  logic                  ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      le_s1 <= 1'b0;
      le_s2 <= 1'b0;
      le_d  <= 1'b0;
      rdy_d <= 1'b0;
    end else begin
      le_s1 <= load_en;
      le_s2 <= le_s1;
      le_d  <= le_s2;
      rdy_d <= rx_byte_ready;
    end
  end

  assign le_rise = le_s2 & ~le_d;
  assign le_fall = ~le_s2 & le_d;
  assign rx_edge = rx_byte_ready & ~rdy_d;

  // A load_en rise seen mid-write is parked until the FSM is back in IDLE.
  assign do_clear = (le_rise | clr_pend) & (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clr_pend <= 1'b0;
    else      clr_pend <= (le_rise | clr_pend) & ~do_clear;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= BYTE_HI;
      hi_byte   <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= 1'b0;
      if (do_clear || le_fall) begin
        phase <= BYTE_HI;
      end else if (rx_edge && le_s2) begin
        if (phase == BYTE_HI) begin
          hi_byte <= rx_byte;
          phase   <= BYTE_LO;
        end else begin
          push_word <= {hi_byte, rx_byte};
          push_q    <= 1'b1;
          phase     <= BYTE_HI;
        end
      end
    end
  end

  loader_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .pop     (ack),
    .flush   (do_clear),
    .wdata   (push_word),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dropped (fifo_dropped)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = WAIT;
      WAIT:    if (ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue         = (state == IDLE) & ~fifo_empty & dram_mem_ready & ~do_clear;
    ack           = (state == WAIT) & dram_data_ready;
    dram_write_en = (state == WAIT);
    busy          = ~fifo_empty | (state == WAIT);
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          csum_q <= '0;
    else if (ack)      csum_q <= csum_q + data_q;
    else if (do_clear) csum_q <= '0;
  end

  assign checksum = csum_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= 1'b0;
      data_q   <= '0;
      addr_q   <= BASE_ADDR;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      strobe_q <= issue;
      if (issue) data_q <= fifo_rdata;
      if (ack) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end else if (do_clear) begin
        addr_q  <= BASE_ADDR;
        count_q <= '0;
      end
      if (do_clear)          ovf_q <= 1'b0;
      else if (fifo_dropped) ovf_q <= 1'b1;
    end
  end

  assign dram_refresh_data = strobe_q;
  assign dram_addr         = addr_q;
  assign dram_data_in      = data_q;
  assign word_count        = count_q;
  assign overflow          = ovf_q;

endmodule
